// File: rtl/magic_button_ctl.sv
// Front-panel MAGIC button conditioner: synchronise, debounce, classify short/long
// presses, and hold the short-press request until it is consumed at a frame edge.
module magic_button_ctl #(
    parameter int DEBOUNCE_CYCLES   = 140000,
    parameter int LONG_PRESS_FRAMES = 100
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic btn_n,
    input  logic n_int,
    input  logic n_int_next,
    output logic magic_button,
    output logic reboot_req,
    output logic btn_pressed
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = $clog2(LONG_PRESS_FRAMES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(LONG_PRESS_FRAMES - 1);
    localparam logic [FW-1:0] FR_MAX  = FW'(LONG_PRESS_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_ARMED,
        ST_WAIT_RELEASE
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          pressed_q, pressed_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [FW-1:0] frm_cnt_q, frm_cnt_d;
    state_t        state_q, state_d;
    logic          magic_q, magic_d;
    logic          reboot_q, reboot_d;

    logic s_pressed;
    logic frame_stb;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            pressed_q <= 1'b0;
            db_cnt_q  <= '0;
            frm_cnt_q <= '0;
            state_q   <= ST_IDLE;
            magic_q   <= 1'b0;
            reboot_q  <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pressed_q <= pressed_d;
            db_cnt_q  <= db_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            state_q   <= state_d;
            magic_q   <= magic_d;
            reboot_q  <= reboot_d;
        end
    end

    // Synchroniser and debounce: the counter only runs while the synchronised
    // level disagrees with the debounced one, so any agreement restarts it.
    always_comb begin
        sync1_d   = btn_n;
        sync2_d   = sync1_q;
        s_pressed = !sync2_q;
        pressed_d = pressed_q;
        db_cnt_d  = '0;
        if (s_pressed != pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                pressed_d = s_pressed;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    always_comb begin
        frame_stb = n_int && !n_int_next;
        state_d   = state_q;
        frm_cnt_d = frm_cnt_q;
        magic_d   = magic_q;
        reboot_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed_q) begin
                    state_d   = ST_PRESSED;
                    frm_cnt_d = '0;
                end
            end
            ST_PRESSED: begin
                // Release wins over a same-cycle long-press strobe.
                if (!pressed_q) begin
                    state_d = ST_ARMED;
                    magic_d = 1'b1;
                end else if (frame_stb) begin
                    if (frm_cnt_q == FR_LAST) begin
                        reboot_d = 1'b1;
                        state_d  = ST_WAIT_RELEASE;
                    end else if (frm_cnt_q != FR_MAX) begin
                        frm_cnt_d = frm_cnt_q + FW'(1);
                    end
                end
            end
            ST_ARMED: begin
                // Held through the strobe cycle so the consumer samples it once.
                if (frame_stb) begin
                    magic_d = 1'b0;
                    state_d = pressed_q ? ST_WAIT_RELEASE : ST_IDLE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!pressed_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign magic_button = magic_q;
    assign reboot_req   = reboot_q;
    assign btn_pressed  = pressed_q;

endmodule

// File: tb/tb_magic_button_ctl.sv
// Scoreboard bench for magic_button_ctl: a press-level reference model pushes the
// expected outputs each clock; a negedge monitor pops and compares.
module tb_magic_button_ctl;

    localparam int DB    = 16;
    localparam int LPF   = 4;
    localparam int FRAME = 200;

    typedef struct packed {
        logic magic;
        logic reboot;
        logic pressed;
    } exp_t;

    logic clk28 = 1'b0;
    logic rst_n = 1'b0;
    logic btn_n = 1'b1;
    logic n_int = 1'b1;
    logic n_int_next = 1'b1;
    logic magic_button, reboot_req, btn_pressed;

    bit   frames_on = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    magic_button_ctl #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_FRAMES(LPF)
    ) dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .btn_n       (btn_n),
        .n_int       (n_int),
        .n_int_next  (n_int_next),
        .magic_button(magic_button),
        .reboot_req  (reboot_req),
        .btn_pressed (btn_pressed)
    );

    always #5 clk28 = ~clk28;

    // n_int is low for the first 20 cycles of each frame; the strobe is the
    // cycle just before it falls.
    function automatic logic n_int_at(int c);
        if (!frames_on) return 1'b1;
        return (c % FRAME) >= 20;
    endfunction

    always @(posedge clk28) begin
        #1;
        n_int      = n_int_at(cyc);
        n_int_next = n_int_at(cyc + 1);
    end

    // Reference model: debounced level flips once the delayed pin has been
    // stable and different for DB evaluations; press bookkeeping by flags.
    logic m_d1 = 1'b1, m_d2 = 1'b1, m_s_prev = 1'b0, m_pressed = 1'b0;
    int   m_stable_since = 0;
    bit   m_req = 0, m_waiting = 0, m_tracking = 0;
    int   m_frames = 0;

    always @(posedge clk28) begin
        logic s, p, stb, pulse;
        cyc++;
        if (!rst_n) begin
            m_d1 = 1'b1; m_d2 = 1'b1; m_s_prev = 1'b0; m_pressed = 1'b0;
            m_stable_since = cyc;
            m_req = 0; m_waiting = 0; m_tracking = 0; m_frames = 0;
            exp_q.push_back('{1'b0, 1'b0, 1'b0});
        end else begin
            s    = !m_d2;
            m_d2 = m_d1;
            m_d1 = btn_n;
            if (s != m_s_prev) begin
                m_s_prev       = s;
                m_stable_since = cyc;
            end
            p     = m_pressed;
            stb   = n_int && !n_int_next;
            pulse = 1'b0;
            if (s != m_pressed && (cyc - m_stable_since) == DB - 1) m_pressed = s;
            if (m_req) begin
                if (stb) begin
                    m_req     = 0;
                    m_waiting = p;
                end
            end else if (m_waiting) begin
                if (!p) m_waiting = 0;
            end else if (m_tracking) begin
                if (!p) begin
                    m_tracking = 0;
                    m_req      = 1;
                end else if (stb) begin
                    m_frames++;
                    if (m_frames == LPF) begin
                        pulse      = 1'b1;
                        m_tracking = 0;
                        m_waiting  = 1;
                    end
                end
            end else if (p) begin
                m_tracking = 1;
                m_frames   = 0;
            end
            exp_q.push_back('{m_req, pulse, m_pressed});
        end
    end

    always @(negedge clk28) begin
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty cycle=%0d", cyc);
        end else begin
            e = exp_q.pop_front();
            if (magic_button !== e.magic || reboot_req !== e.reboot || btn_pressed !== e.pressed) begin
                miscompares++;
                $display("FAIL outputs cycle=%0d got magic=%b reboot=%b pressed=%b want magic=%b reboot=%b pressed=%b",
                         cyc, magic_button, reboot_req, btn_pressed, e.magic, e.reboot, e.pressed);
            end
        end
    end

    task automatic drive(input logic v, input int n);
        btn_n = v;
        repeat (n) begin
            @(posedge clk28);
            #1;
        end
    endtask

    task automatic wait_phase(input int ph);
        do begin
            @(posedge clk28);
            #1;
        end while ((cyc % FRAME) != ph);
    endtask

    initial begin
        repeat (4) @(posedge clk28);
        @(negedge clk28);
        #1 rst_n = 1'b1;

        // bounce that never survives the debounce window
        wait_phase(0);
        drive(1'b0, 10); drive(1'b1, 5); drive(1'b0, 10); drive(1'b1, 150);

        // short press
        wait_phase(0);
        drive(1'b0, 100); drive(1'b1, 300);

        // long press across four strobes
        wait_phase(50);
        drive(1'b0, 4 * FRAME + 100); drive(1'b1, 300);

        // debounced release lands exactly on a strobe cycle
        wait_phase(100);
        btn_n = 1'b0;
        wait_phase(181);
        drive(1'b1, 450);

        // re-press while armed
        wait_phase(0);
        drive(1'b0, 40); drive(1'b1, 30); drive(1'b0, 330); drive(1'b1, 300);

        // reset mid-press with the button held
        wait_phase(0);
        drive(1'b0, 40);
        @(negedge clk28);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({magic_button, reboot_req, btn_pressed} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset got %b%b%b want 000", magic_button, reboot_req, btn_pressed);
        end
        repeat (3) @(posedge clk28);
        @(negedge clk28);
        #1 rst_n = 1'b1;
        @(posedge clk28);
        #1;
        drive(1'b0, 60); drive(1'b1, 400);

        // frame interrupts stalled: request must be held until they resume
        wait_phase(0);
        frames_on = 1'b0;
        drive(1'b0, 60); drive(1'b1, 600);
        frames_on = 1'b1;
        drive(1'b1, 300);

        // randomised presses with bounce
        for (int it = 0; it < 25; it++) begin
            int nb;
            int kind;
            int len;
            nb = $urandom_range(0, 4);
            for (int k = 0; k < nb; k++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
            kind = $urandom_range(0, 2);
            len  = (kind == 0) ? $urandom_range(5, 30) :
                   (kind == 1) ? $urandom_range(60, 400) : $urandom_range(700, 1000);
            drive(1'b0, len);
            nb = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 12));
            drive(1'b1, $urandom_range(20, 350));
        end

        repeat (5) @(posedge clk28);
        @(negedge clk28);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
